sync_fifo_ovf: RTL and testbench
================================

Name: sync_fifo_ovf

Overview:
Parametrised synchronous FIFO; successor to the team's basic sync FIFO. Adds any-depth support (not only powers of two), an empty-FIFO bypass, a correct simultaneous read+write when full, and an optional overwrite-oldest mode. Also adds almost-full/almost-empty thresholds, a synchronous flush and a saturating drop counter. Used as a trace/debug buffer between the CPU-side capture logic and the readout path.

Parameters:
DATA_WIDTH, 32, entry width in bits (>=1)
DATA_DEPTH, 8, number of entries; any integer >=2
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DATA_DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DATA_DEPTH-1)
OVERWRITE, 0, 0 = reject writes when full; 1 = discard oldest entry and accept the write
DROP_CNT_W, 16, width of the drop counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-high
clear  in  1  synchronous flush; empties the FIFO
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  registered read data; holds its value between reads
rd_valid  out  1  one-cycle pulse: rd_data was updated this cycle
full  out  1  level == DATA_DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  clog2(DATA_DEPTH+1)  current occupancy
wr_drop  out  1  one-cycle pulse: a write was rejected (OVERWRITE=0) or the oldest entry was discarded (OVERWRITE=1)
drop_cnt  out  DROP_CNT_W  saturating count of wr_drop events

Behaviour:
- Reset (asynchronous, rst=1): level=0, wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, wr_drop=0, drop_cnt=0. Memory contents are not reset.
- Reset mid-operation: all in-flight state is lost; the first cycle after rst deasserts behaves as an empty FIFO.
- Flags full/empty/almost_* are combinational decodes of the registered level only; no input-to-flag paths.
- Pointers: range 0..DATA_DEPTH-1. On increment they wrap from DATA_DEPTH-1 to 0 by explicit compare, not by bit overflow.
- Read latency: 1 cycle. rd_en accepted at edge N gives rd_data and rd_valid=1 after edge N.
- Cases per edge, with clear=0; E = empty, F = full (pre-edge values):
  - rd=0, wr=0: hold. rd_valid=0, wr_drop=0.
  - wr only, !F: store at wr_ptr; wr_ptr+1; level+1.
  - wr only, F, OVERWRITE=0: write ignored; wr_drop=1; drop_cnt+1.
  - wr only, F, OVERWRITE=1: store at wr_ptr; wr_ptr+1; rd_ptr+1; level stays DATA_DEPTH; wr_drop=1; drop_cnt+1.
  - rd only, !E: rd_data<=mem[rd_ptr]; rd_ptr+1; level-1; rd_valid=1.
  - rd only, E: no change; rd_valid=0. Not an error.
  - rd+wr, E (bypass): rd_data<=wr_data; rd_valid=1; level stays 0; pointers unchanged.
  - rd+wr, !E (including F): rd_data<=mem[rd_ptr]; store wr_data at wr_ptr; both pointers +1; level unchanged; rd_valid=1; no drop.
- clear=1: pointers and level go to 0; wr_en/rd_en ignored that cycle; rd_valid=0; rd_data holds; drop_cnt is NOT cleared.
- drop_cnt saturates at all-ones and never wraps.
- level width is clog2(DATA_DEPTH+1) so DATA_DEPTH is representable. All comparisons are unsigned.
- No X on outputs after reset. Memory is inferable as distributed/LUT RAM (one write port, one registered read).

Decomposition:
- Package fifo_pkg: OVERWRITE mode constants (FIFO_MODE_REJECT=0, FIFO_MODE_OVERWRITE=1) and a helper function for level width.
- Sub-module fifo_wrap_ptr: parametrised modulo-DATA_DEPTH pointer with inc, clear and async rst. Instantiated twice (wr_ptr, rd_ptr).
- Storage array, level and flag logic stay in the top module.

Test Plan:
- Depth 5, OVERWRITE=0: write 0x11..0x55, then one more write (0x66) -> full=1, wr_drop pulse, drop_cnt=1; 5 reads return 0x11..0x55 in order with rd_valid each cycle; empty=1 at end.
- Depth 5, OVERWRITE=1: write 0x01..0x07 -> level=5, drop_cnt=2; reads return 0x03,0x04,0x05,0x06,0x07; pointer wrap past index 4 is correct.
- Empty bypass: rd_en=wr_en=1 with wr_data=0xABCD while empty -> next cycle rd_data=0xABCD, rd_valid=1, level=0, empty=1.
- Full simultaneous: fill depth 8 with 0..7, then rd_en=wr_en=1 with 0x99 for one cycle -> rd_data=0, level=8, wr_drop=0; draining yields 1..7 then 0x99.
- Thresholds (AF=6, AE=2): step level 0..8..0 -> almost_empty high for levels 0-2, almost_full high for levels 6-8; rd_en on empty -> rd_valid=0 and rd_data unchanged.
- rst asserted asynchronously mid-burst at level 4 with drop_cnt=3 -> outputs reset immediately without waiting for a clock edge; clear at level 3 -> level=0 next cycle and drop_cnt still 3.

Source files
------------

// File: rtl/sync_fifo_ovf_pkg.sv
// fifo_pkg: definitions shared by the sync_fifo_ovf design files.
//   fifo_mode_e : full-FIFO write policy (reject the write, or overwrite the oldest entry)
//   fifo_lvl_w  : width of an occupancy counter that can hold 0..depth
package fifo_pkg;

    typedef enum int {
        FIFO_MODE_REJECT    = 0,
        FIFO_MODE_OVERWRITE = 1
    } fifo_mode_e;

    // Occupancy can reach depth itself, so depth+1 distinct values are needed.
    function automatic int fifo_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ovf_if.sv
// sync_fifo_ovf_if: the FIFO's request/response bundle.
//   master : producer/consumer side (drives clear, wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives rd_data, rd_valid, flags, level, wr_drop, drop_cnt)
interface sync_fifo_ovf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int DROP_CNT_W = 16
);
    import fifo_pkg::*;

    localparam int LVL_W = fifo_lvl_w(DATA_DEPTH);

    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LVL_W-1:0]      level;
    logic                  wr_drop;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, wr_drop, drop_cnt
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, wr_drop, drop_cnt
    );

endinterface

// File: rtl/sync_fifo_ovf_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer for any DEPTH >= 2.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   clr_i    : synchronous return to 0 (has priority over inc_i)
//   inc_i    : advance by one, wrapping DEPTH-1 -> 0
//   ptr_o    : current pointer value
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Wrap by explicit compare so non-power-of-two depths never visit
    // the unused codes above DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ovf.sv
// sync_fifo_ovf: any-depth synchronous FIFO with empty bypass, full read+write,
// optional overwrite-oldest mode, almost-full/empty thresholds, synchronous
// flush and a saturating drop counter.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sync_fifo_ovf_if.slave
//              in : clear, wr_en, wr_data, rd_en
//              out: rd_data (registered), rd_valid, full, empty, almost_full,
//                   almost_empty, level, wr_drop, drop_cnt
module sync_fifo_ovf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int OVERWRITE  = FIFO_MODE_REJECT,
    parameter int DROP_CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_ovf_if.slave  bus
);

    localparam int LVL_W  = fifo_lvl_w(DATA_DEPTH);
    localparam int PTR_W  = $clog2(DATA_DEPTH);
    localparam bit OVW_EN = (OVERWRITE == FIFO_MODE_OVERWRITE);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DATA_DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [LVL_W-1:0]      level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_drop_q, wr_drop_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  wr_inc, rd_inc, mem_we;
    logic                  full, empty;

    fifo_wrap_ptr #(.DEPTH(DATA_DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clear),
        .inc_i (wr_inc),
        .ptr_o (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DATA_DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clear),
        .inc_i (rd_inc),
        .ptr_o (rd_ptr)
    );

    // Flags decode only the registered level.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    always_comb begin
        mem_we     = 1'b0;
        wr_inc     = 1'b0;
        rd_inc     = 1'b0;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_drop_d  = 1'b0;
        if (bus.clear) begin
            level_d = '0;
        end else begin
            unique case ({bus.wr_en, bus.rd_en})
                2'b10: begin
                    if (!full) begin
                        mem_we  = 1'b1;
                        wr_inc  = 1'b1;
                        level_d = level_q + 1'b1;
                    end else begin
                        wr_drop_d = 1'b1;
                        // Overwrite: advancing rd_ptr discards the oldest entry,
                        // and the slot it frees is exactly wr_ptr.
                        if (OVW_EN) begin
                            mem_we = 1'b1;
                            wr_inc = 1'b1;
                            rd_inc = 1'b1;
                        end
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        rd_data_d  = mem[rd_ptr];
                        rd_valid_d = 1'b1;
                        rd_inc     = 1'b1;
                        level_d    = level_q - 1'b1;
                    end
                end
                2'b11: begin
                    if (empty) begin
                        // Bypass: the written word goes straight to rd_data.
                        rd_data_d  = bus.wr_data;
                        rd_valid_d = 1'b1;
                    end else begin
                        // When full rd_ptr == wr_ptr; the read samples the old
                        // word before the write lands at the same edge.
                        rd_data_d  = mem[rd_ptr];
                        rd_valid_d = 1'b1;
                        mem_we     = 1'b1;
                        wr_inc     = 1'b1;
                        rd_inc     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        drop_cnt_d = (wr_drop_d && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_drop_q  <= wr_drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= LVL_AF);
    assign bus.almost_empty = (level_q <= LVL_AE);
    assign bus.level        = level_q;
    assign bus.wr_drop      = wr_drop_q;
    assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_sync_fifo_ovf.sv
// tb_sync_fifo_ovf: three FIFO configurations driven by one shared stimulus
// stream and checked every cycle against a queue-based reference model.
//   inst 0: depth 5, reject,    AF=4, AE=1, 16-bit drop counter
//   inst 1: depth 5, overwrite, AF=3, AE=1, 3-bit drop counter (saturates)
//   inst 2: depth 8, reject,    AF=6, AE=2, 16-bit drop counter
module tb_sync_fifo_ovf;
    import fifo_pkg::*;

    localparam int DW = 16;
    localparam int          D    [3] = '{5, 5, 8};
    localparam int          OVW  [3] = '{0, 1, 0};
    localparam int          AF   [3] = '{4, 3, 6};
    localparam int          AE   [3] = '{1, 1, 2};
    localparam int unsigned CMAX [3] = '{65535, 7, 65535};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    sync_fifo_ovf_if #(.DATA_WIDTH(DW), .DATA_DEPTH(5), .DROP_CNT_W(16)) bus0 ();
    sync_fifo_ovf_if #(.DATA_WIDTH(DW), .DATA_DEPTH(5), .DROP_CNT_W(3))  bus1 ();
    sync_fifo_ovf_if #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .DROP_CNT_W(16)) bus2 ();

    assign bus0.clear = clear;  assign bus0.wr_en = wr_en;
    assign bus0.rd_en = rd_en;  assign bus0.wr_data = wr_data;
    assign bus1.clear = clear;  assign bus1.wr_en = wr_en;
    assign bus1.rd_en = rd_en;  assign bus1.wr_data = wr_data;
    assign bus2.clear = clear;  assign bus2.wr_en = wr_en;
    assign bus2.rd_en = rd_en;  assign bus2.wr_data = wr_data;

    sync_fifo_ovf #(
        .DATA_WIDTH(DW), .DATA_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1),
        .OVERWRITE(FIFO_MODE_REJECT), .DROP_CNT_W(16)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    sync_fifo_ovf #(
        .DATA_WIDTH(DW), .DATA_DEPTH(5), .AF_THRESH(3), .AE_THRESH(1),
        .OVERWRITE(FIFO_MODE_OVERWRITE), .DROP_CNT_W(3)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    sync_fifo_ovf #(
        .DATA_WIDTH(DW), .DATA_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2),
        .OVERWRITE(FIFO_MODE_REJECT), .DROP_CNT_W(16)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Reference model: contents as a queue, oldest at the front.
    logic [DW-1:0] mq [3][$];
    logic [DW-1:0] m_rdata [3];
    logic          m_vld   [3];
    logic          m_drop  [3];
    int unsigned   m_cnt   [3];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_rdata[k] = '0;
            m_vld[k]   = 1'b0;
            m_drop[k]  = 1'b0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] din);
        for (int k = 0; k < 3; k++) begin
            m_vld[k]  = 1'b0;
            m_drop[k] = 1'b0;
            if (c) begin
                mq[k].delete();
            end else if (w && r && mq[k].size() == 0) begin
                m_rdata[k] = din;
                m_vld[k]   = 1'b1;
            end else begin
                if (r && mq[k].size() != 0) begin
                    m_rdata[k] = mq[k].pop_front();
                    m_vld[k]   = 1'b1;
                end
                if (w) begin
                    if (mq[k].size() < D[k]) begin
                        mq[k].push_back(din);
                    end else begin
                        m_drop[k] = 1'b1;
                        if (OVW[k] != 0) begin
                            void'(mq[k].pop_front());
                            mq[k].push_back(din);
                        end
                    end
                end
            end
            if (m_drop[k] && m_cnt[k] < CMAX[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_one(input int k, input logic rv, input logic dr, input logic [31:0] rd,
                             input logic [31:0] lvl, input logic f, input logic e,
                             input logic af, input logic ae, input logic [31:0] cnt);
        int sz;
        sz = mq[k].size();
        chk($sformatf("i%0d.rd_valid", k), 32'(rv), 32'(m_vld[k]));
        chk($sformatf("i%0d.wr_drop", k), 32'(dr), 32'(m_drop[k]));
        chk($sformatf("i%0d.rd_data", k), rd, 32'(m_rdata[k]));
        chk($sformatf("i%0d.level", k), lvl, 32'(sz));
        chk($sformatf("i%0d.full", k), 32'(f), 32'(sz == D[k]));
        chk($sformatf("i%0d.empty", k), 32'(e), 32'(sz == 0));
        chk($sformatf("i%0d.almost_full", k), 32'(af), 32'(sz >= AF[k]));
        chk($sformatf("i%0d.almost_empty", k), 32'(ae), 32'(sz <= AE[k]));
        chk($sformatf("i%0d.drop_cnt", k), cnt, m_cnt[k]);
    endtask

    task automatic check_all();
        check_one(0, bus0.rd_valid, bus0.wr_drop, 32'(bus0.rd_data), 32'(bus0.level), bus0.full,
                  bus0.empty, bus0.almost_full, bus0.almost_empty, 32'(bus0.drop_cnt));
        check_one(1, bus1.rd_valid, bus1.wr_drop, 32'(bus1.rd_data), 32'(bus1.level), bus1.full,
                  bus1.empty, bus1.almost_full, bus1.almost_empty, 32'(bus1.drop_cnt));
        check_one(2, bus2.rd_valid, bus2.wr_drop, 32'(bus2.rd_data), 32'(bus2.level), bus2.full,
                  bus2.empty, bus2.almost_full, bus2.almost_empty, 32'(bus2.drop_cnt));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic c, input logic w, input logic r, input logic [DW-1:0] din);
        clear   = c;
        wr_en   = w;
        rd_en   = r;
        wr_data = din;
        @(posedge clk);
        model_step(c, w, r, din);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Reset asserted between edges with the previous request still on the bus.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst     = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Overflow: six writes into depth 5 (reject and overwrite) and depth 8.
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i * 'h11));
        for (int i = 0; i < 6; i++)  cycle(1'b0, 1'b0, 1'b1, '0);

        // Overwrite with pointer wrap: 0x01..0x07, then drain.
        async_reset();
        for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 7; i++)  cycle(1'b0, 1'b0, 1'b1, '0);

        // Empty bypass.
        cycle(1'b0, 1'b1, 1'b1, 16'hABCD);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Simultaneous read+write when full, then drain.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b0, 1'b1, 1'b1, 16'h0099);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, '0);

        // Threshold sweep up and down, ending with a read on empty.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(16'h0200 + i));
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, '0);

        // Flush at level 3 with requests asserted in the same cycle.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DW'(16'h0300 + i));
        cycle(1'b1, 1'b1, 1'b1, 16'h0FFF);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Drops, then reset mid-burst.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(16'h0400 + i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, DW'(16'h0500 + i));
        async_reset();

        // Randomized traffic with occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(699) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(39) == 0, $urandom_range(99) < 60,
                      $urandom_range(99) < 50, DW'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
